// File: rtl/count_capture.sv
// Samples an upstream counter, turns every enabled change into a {wrap, value}
// event and queues events in a small FIFO with drop/wrap statistics.
module count_capture #(
    parameter int CNT_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         count,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W:0]           out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               wrap_count,
    output logic [7:0]               drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CNT_W-1:0] count_q,    count_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [LW-1:0]    level_q,    level_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             ovf_q,      ovf_d;
    logic [CNT_W:0]   mem_q [DEPTH];
    logic [CNT_W:0]   mem_d [DEPTH];

    logic is_event;
    logic is_wrap;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    always_comb begin
        is_event  = enable && (count != count_q);
        is_wrap   = is_event && (count_q == {CNT_W{1'b1}}) && (count == '0);
        fifo_full = (level_q == LW'(DEPTH));
        do_pop    = (level_q != '0) && out_ready;
        // A full FIFO still takes the push when the head leaves in the same cycle.
        do_push   = is_event && (!fifo_full || do_pop);
        do_drop   = is_event && !do_push;
    end

    always_comb begin
        count_d    = count;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        wrap_cnt_d = wrap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        mem_d      = mem_q;

        if (clr) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            wrap_cnt_d = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {is_wrap, count};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LW'(1);
            end
            if (is_wrap) begin
                wrap_cnt_d = wrap_cnt_q + 8'd1;
            end
            if (do_drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            wrap_cnt_q <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            wrap_cnt_q <= wrap_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    // Empty FIFO presents zero rather than a stale slot.
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign wrap_count = wrap_cnt_q;
    assign drop_count = drop_cnt_q;
    assign overflow   = ovf_q;

endmodule
